// File: rtl/user_obi_copy_dma.sv
// Single-channel OBI copy engine: streams 32-bit words from SRC to DST one transaction at a time,
// programmed through a small OBI register window, with a sticky DONE/ERR interrupt.

package user_obi_copy_dma_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;
endpackage

module user_obi_copy_dma #(
  parameter int unsigned LenWidth      = 16,
  parameter type         sbr_obi_req_t = user_obi_copy_dma_pkg::obi_req_t,
  parameter type         sbr_obi_rsp_t = user_obi_copy_dma_pkg::obi_rsp_t,
  parameter type         mgr_obi_req_t = user_obi_copy_dma_pkg::obi_req_t,
  parameter type         mgr_obi_rsp_t = user_obi_copy_dma_pkg::obi_rsp_t
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t sbr_obi_req_i,
  output sbr_obi_rsp_t sbr_obi_rsp_o,
  output mgr_obi_req_t mgr_obi_req_o,
  input  mgr_obi_rsp_t mgr_obi_rsp_i,
  output logic         irq_o
);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StWrReq, StWrWait, StDone, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           src_q, src_d, dst_q, dst_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic                  dst_fix_q, dst_fix_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [31:0]           w_src_q, w_src_d, w_dst_q, w_dst_d;
  logic [LenWidth-1:0]   w_cnt_q, w_cnt_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic                  sbr_rvalid_q;
  logic                  sbr_rid_q;
  logic [31:0]           sbr_rdata_q, sbr_rdata_d;

  logic        busy, sbr_wr, start;
  logic [1:0]  reg_sel;
  logic [31:0] len_wr;

  logic unused_bits;
  assign unused_bits = ^{sbr_obi_req_i.a.addr[31:4], sbr_obi_req_i.a.addr[1:0],
                         mgr_obi_rsp_i.r.rid};

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign busy    = (state_q != StIdle);
  assign sbr_wr  = sbr_obi_req_i.req & sbr_obi_req_i.a.we;
  assign reg_sel = sbr_obi_req_i.a.addr[3:2];
  assign len_wr  = apply_be(32'(len_q), sbr_obi_req_i.a.wdata, sbr_obi_req_i.a.be);
  assign irq_o   = done_q | err_q;

  // Read data is captured at the grant cycle and returned one cycle later.
  always_comb begin
    sbr_rdata_d = 32'd0;
    unique case (reg_sel)
      2'd0:    sbr_rdata_d = src_q;
      2'd1:    sbr_rdata_d = dst_q;
      2'd2:    sbr_rdata_d = 32'(len_q);
      2'd3:    sbr_rdata_d = {28'd0, dst_fix_q, err_q, done_q, busy};
      default: sbr_rdata_d = 32'd0;
    endcase
  end

  always_comb begin
    sbr_obi_rsp_o         = '0;
    sbr_obi_rsp_o.gnt     = 1'b1;
    sbr_obi_rsp_o.rvalid  = sbr_rvalid_q;
    sbr_obi_rsp_o.r.rdata = sbr_rdata_q;
    sbr_obi_rsp_o.r.rid   = sbr_rid_q;
    sbr_obi_rsp_o.r.err   = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    dst_fix_d = dst_fix_q;
    done_d    = done_q;
    err_d     = err_q;
    w_src_d   = w_src_q;
    w_dst_d   = w_dst_q;
    w_cnt_d   = w_cnt_q;
    rbuf_d    = rbuf_q;
    start     = 1'b0;
    mgr_obi_req_o = '0;

    // Configuration, START and CLR are only honoured while idle.
    if (sbr_wr && !busy) begin
      unique case (reg_sel)
        2'd0: src_d = apply_be(src_q, sbr_obi_req_i.a.wdata, sbr_obi_req_i.a.be);
        2'd1: dst_d = apply_be(dst_q, sbr_obi_req_i.a.wdata, sbr_obi_req_i.a.be);
        2'd2: len_d = len_wr[LenWidth-1:0];
        2'd3: begin
          if (sbr_obi_req_i.a.be[0]) begin
            start     = sbr_obi_req_i.a.wdata[0];
            dst_fix_d = sbr_obi_req_i.a.wdata[2];
            if (sbr_obi_req_i.a.wdata[1]) begin
              done_d = 1'b0;
              err_d  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_src_d = src_q;
          w_dst_d = dst_q;
          w_cnt_d = len_q;
          state_d = (len_q == '0) ? StDone : StRdReq;
        end
      end
      StRdReq: begin
        mgr_obi_req_o.req    = 1'b1;
        mgr_obi_req_o.a.we   = 1'b0;
        mgr_obi_req_o.a.be   = 4'hF;
        mgr_obi_req_o.a.addr = w_src_q;
        if (mgr_obi_rsp_i.gnt) state_d = StRdWait;
      end
      StRdWait: begin
        if (mgr_obi_rsp_i.rvalid) begin
          rbuf_d  = mgr_obi_rsp_i.r.rdata;
          state_d = mgr_obi_rsp_i.r.err ? StErr : StWrReq;
        end
      end
      StWrReq: begin
        mgr_obi_req_o.req     = 1'b1;
        mgr_obi_req_o.a.we    = 1'b1;
        mgr_obi_req_o.a.be    = 4'hF;
        mgr_obi_req_o.a.addr  = w_dst_q;
        mgr_obi_req_o.a.wdata = rbuf_q;
        if (mgr_obi_rsp_i.gnt) state_d = StWrWait;
      end
      StWrWait: begin
        if (mgr_obi_rsp_i.rvalid) begin
          if (mgr_obi_rsp_i.r.err) begin
            state_d = StErr;
          end else begin
            w_cnt_d = w_cnt_q - 1'b1;
            w_src_d = w_src_q + 32'd4;
            if (!dst_fix_q) w_dst_d = w_dst_q + 32'd4;
            state_d = (w_cnt_q != 1) ? StRdReq : StDone;
          end
        end
      end
      // Placed after the CLR decode so a simultaneous set wins.
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      dst_fix_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      w_src_q      <= '0;
      w_dst_q      <= '0;
      w_cnt_q      <= '0;
      rbuf_q       <= '0;
      sbr_rvalid_q <= 1'b0;
      sbr_rid_q    <= 1'b0;
      sbr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      dst_fix_q    <= dst_fix_d;
      done_q       <= done_d;
      err_q        <= err_d;
      w_src_q      <= w_src_d;
      w_dst_q      <= w_dst_d;
      w_cnt_q      <= w_cnt_d;
      rbuf_q       <= rbuf_d;
      sbr_rvalid_q <= sbr_obi_req_i.req;
      if (sbr_obi_req_i.req) begin
        sbr_rid_q   <= sbr_obi_req_i.a.aid;
        sbr_rdata_q <= sbr_rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_user_obi_copy_dma.sv
// Bench for user_obi_copy_dma: a stalling OBI memory model with read/write scoreboards and
// one task per scenario.

module tb_user_obi_copy_dma;
  import user_obi_copy_dma_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  obi_req_t sbr_req = '0;
  obi_rsp_t sbr_rsp;
  obi_req_t mgr_req;
  obi_rsp_t mgr_rsp;
  logic     irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];

  int unsigned gnt_lo = 0, gnt_hi = 0, rv_lo = 0, rv_hi = 0;
  int          err_rd_idx = 0;
  int          rd_cnt = 0, wr_cnt = 0;
  logic        req_seen = 1'b0;
  logic [31:0] rd_addr_last [2];

  logic        pend_rv = 1'b0, pend_err = 1'b0, held = 1'b0;
  logic [31:0] pend_data = '0;
  int unsigned rv_wait = 0, gnt_wait = 0;
  obi_a_chan_t held_a;

  always #5 clk = ~clk;

  user_obi_copy_dma dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sbr_obi_req_i(sbr_req),
    .sbr_obi_rsp_o(sbr_rsp),
    .mgr_obi_req_o(mgr_req),
    .mgr_obi_rsp_i(mgr_rsp),
    .irq_o        (irq)
  );

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory model: drives gnt/rvalid at negedges, checks traffic against the scoreboards.
  initial begin
    mgr_rsp = '0;
    forever begin
      @(negedge clk);
      mgr_rsp.gnt    = 1'b0;
      mgr_rsp.rvalid = 1'b0;
      if (mgr_req.req) req_seen = 1'b1;
      if (pend_rv) begin
        if (rv_wait == 0) begin
          mgr_rsp.rvalid  = 1'b1;
          mgr_rsp.r.rdata = pend_data;
          mgr_rsp.r.err   = pend_err;
          pend_rv = 1'b0;
        end else begin
          rv_wait--;
        end
      end else if (mgr_req.req) begin
        if (!held) begin
          held     = 1'b1;
          held_a   = mgr_req.a;
          gnt_wait = $urandom_range(gnt_hi, gnt_lo);
        end else begin
          checks++;
          if (mgr_req.a !== held_a) begin
            errors++;
            $display("FAIL req_stable: got %h required %h", mgr_req.a, held_a);
          end
        end
        if (gnt_wait == 0) begin
          mgr_rsp.gnt = 1'b1;
          held = 1'b0;
          checks++;
          if (!mgr_req.a.we) begin
            rd_cnt++;
            if (rd_cnt <= 2) rd_addr_last[rd_cnt-1] = mgr_req.a.addr;
            if (exp_rd_q.size() == 0) begin
              errors++;
              $display("FAIL rd_unexpected: got addr %h required none", mgr_req.a.addr);
            end else begin
              logic [31:0] e;
              e = exp_rd_q.pop_front();
              if (mgr_req.a.addr !== e || mgr_req.a.be !== 4'hF || mgr_req.a.aid !== 1'b0) begin
                errors++;
                $display("FAIL rd_req: got addr %h be %h required addr %h be f", mgr_req.a.addr,
                         mgr_req.a.be, e);
              end
            end
            pend_data = rd_val(mgr_req.a.addr);
            pend_err  = (rd_cnt == err_rd_idx);
          end else begin
            wr_cnt++;
            if (exp_wr_q.size() == 0) begin
              errors++;
              $display("FAIL wr_unexpected: got addr %h data %h required none", mgr_req.a.addr,
                       mgr_req.a.wdata);
            end else begin
              wr_t e;
              e = exp_wr_q.pop_front();
              if (mgr_req.a.addr !== e.addr || mgr_req.a.wdata !== e.data ||
                  mgr_req.a.be !== 4'hF) begin
                errors++;
                $display("FAIL wr_req: got addr %h data %h required addr %h data %h",
                         mgr_req.a.addr, mgr_req.a.wdata, e.addr, e.data);
              end
            end
            pend_data = '0;
            pend_err  = 1'b0;
          end
          pend_rv = 1'b1;
          rv_wait = $urandom_range(rv_hi, rv_lo);
        end else begin
          gnt_wait--;
        end
      end
    end
  end

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    sbr_req.req     = 1'b1;
    sbr_req.a.we    = 1'b1;
    sbr_req.a.addr  = addr;
    sbr_req.a.be    = 4'hF;
    sbr_req.a.wdata = data;
    sbr_req.a.aid   = 1'b0;
    @(negedge clk);
    sbr_req = '0;
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    sbr_req.req    = 1'b1;
    sbr_req.a.we   = 1'b0;
    sbr_req.a.addr = addr;
    sbr_req.a.aid  = 1'b1;
    @(negedge clk);
    sbr_req = '0;
    data = sbr_rsp.r.rdata;
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input logic [31:0] ctrl);
    reg_write(32'h0, src);
    reg_write(32'h4, dst);
    reg_write(32'h8, len);
    reg_write(32'hC, ctrl | 32'h1);
  endtask

  task automatic push_exp(input logic [31:0] src, input logic [31:0] dst, input int n_rd,
                          input int n_wr, input logic fix);
    for (int i = 0; i < n_rd; i++) exp_rd_q.push_back(src + 32'(4 * i));
    for (int i = 0; i < n_wr; i++) begin
      wr_t w;
      w.addr = fix ? dst : dst + 32'(4 * i);
      w.data = rd_val(src + 32'(4 * i));
      exp_wr_q.push_back(w);
    end
  endtask

  task automatic wait_irq(input int max, output int cyc);
    cyc = 0;
    while (!irq && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got rd %0d wr %0d left required 0 0", name, exp_rd_q.size(),
               exp_wr_q.size());
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mgr_req !== '0 || sbr_rsp.rvalid !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req %h rvalid %b irq %b required 0 0 0", mgr_req,
               sbr_rsp.rvalid, irq);
    end
    rst = 1'b0;
    reg_read(32'hC, d);
    checks++;
    if (d !== 32'h0 || sbr_rsp.rvalid !== 1'b1 || sbr_rsp.r.rid !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: got %h rvalid %b rid %b required 0 1 1", d, sbr_rsp.rvalid,
               sbr_rsp.r.rid);
    end
    reg_read(32'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_src: got %h required 0", d);
    end
  endtask

  task automatic test_basic_copy();
    int cyc;
    logic [31:0] d;
    gnt_lo = 0; gnt_hi = 0; rv_lo = 0; rv_hi = 0; err_rd_idx = 0;
    push_exp(32'h1000_0000, 32'h2000_0000, 4, 4, 1'b0);
    start_copy(32'h1000_0000, 32'h2000_0000, 4, 0);
    wait_irq(200, cyc);
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL basic_irq_latency: got %0d required 17", cyc);
    end
    reg_read(32'hC, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL basic_status: got %h required 2", d);
    end
    check_drained("basic");
    reg_write(32'hC, 32'h2);
  endtask

  task automatic test_dst_fix_stalls();
    int cyc;
    logic [31:0] d;
    gnt_lo = 0; gnt_hi = 5; rv_lo = 0; rv_hi = 5; err_rd_idx = 0;
    push_exp(32'h1000_0100, 32'h2000_0040, 3, 3, 1'b1);
    start_copy(32'h1000_0100, 32'h2000_0040, 3, 32'h4);
    wait_irq(500, cyc);
    checks++;
    if (!irq) begin
      errors++;
      $display("FAIL fix_irq: got 0 required 1");
    end
    reg_read(32'hC, d);
    checks++;
    if (d !== 32'hA) begin
      errors++;
      $display("FAIL fix_status: got %h required a", d);
    end
    check_drained("fix");
    reg_write(32'hC, 32'h2);
    reg_read(32'hC, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL fix_clr_status: got %h required 0", d);
    end
  endtask

  task automatic test_read_error();
    int cyc;
    logic [31:0] d;
    gnt_lo = 0; gnt_hi = 0; rv_lo = 0; rv_hi = 0;
    rd_cnt = 0; wr_cnt = 0; err_rd_idx = 2;
    push_exp(32'h1000_0200, 32'h2000_0200, 2, 1, 1'b0);
    start_copy(32'h1000_0200, 32'h2000_0200, 4, 0);
    wait_irq(200, cyc);
    repeat (5) @(negedge clk);
    checks++;
    if (wr_cnt != 1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL err_writes: got %0d irq %b required 1 1", wr_cnt, irq);
    end
    reg_read(32'hC, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL err_status: got %h required 4", d);
    end
    check_drained("err");
    reg_write(32'hC, 32'h2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL err_clr_irq: got %b required 0", irq);
    end
    err_rd_idx = 0;
  endtask

  task automatic test_len_zero();
    int cyc;
    logic [31:0] d;
    reg_write(32'h8, 32'h0);
    req_seen = 1'b0;
    reg_write(32'hC, 32'h1);
    wait_irq(20, cyc);
    repeat (3) @(negedge clk);
    checks++;
    if (cyc > 2 || req_seen !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL len0: got cyc %0d req_seen %b irq %b required <=2 0 1", cyc, req_seen, irq);
    end
    reg_read(32'hC, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL len0_status: got %h required 2", d);
    end
    reg_write(32'hC, 32'h2);
  endtask

  task automatic test_busy_writes();
    int cyc;
    logic [31:0] d;
    gnt_lo = 3; gnt_hi = 3; rv_lo = 0; rv_hi = 0;
    push_exp(32'h1000_0300, 32'h2000_0300, 4, 4, 1'b0);
    start_copy(32'h1000_0300, 32'h2000_0300, 4, 0);
    reg_write(32'h0, 32'hDEAD_BEEF);
    reg_write(32'h8, 32'h9);
    reg_write(32'hC, 32'h1);
    reg_read(32'hC, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL busy_status: got %h required 1", d);
    end
    wait_irq(500, cyc);
    repeat (10) @(negedge clk);
    check_drained("busy");
    reg_read(32'h0, d);
    checks++;
    if (d !== 32'h1000_0300) begin
      errors++;
      $display("FAIL busy_src_readback: got %h required 10000300", d);
    end
    reg_read(32'h8, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL busy_len_readback: got %h required 4", d);
    end
    reg_write(32'hC, 32'h2);
  endtask

  task automatic test_wrap_reset();
    int cyc;
    logic [31:0] d;
    gnt_lo = 0; gnt_hi = 0; rv_lo = 3; rv_hi = 3;
    rd_cnt = 0;
    push_exp(32'hFFFF_FFFC, 32'h3000_0000, 2, 2, 1'b0);
    start_copy(32'hFFFF_FFFC, 32'h3000_0000, 2, 0);
    cyc = 0;
    while (rd_cnt < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rd_cnt < 2 || rd_addr_last[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got reads %0d addr %h required 2 0", rd_cnt, rd_addr_last[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mgr_req.req !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_copy: got req %b irq %b required 0 0", mgr_req.req, irq);
    end
    repeat (8) @(negedge clk);
    reg_read(32'hC, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0 || mgr_req.req !== 1'b0) begin
      errors++;
      $display("FAIL rst_status: got %h irq %b req %b required 0 0 0", d, irq, mgr_req.req);
    end
    checks++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 1) begin
      errors++;
      $display("FAIL rst_traffic: got rd %0d wr %0d left required 0 1", exp_rd_q.size(),
               exp_wr_q.size());
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_dst_fix_stalls();
    test_read_error();
    test_len_zero();
    test_busy_writes();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
